// File: rtl/clkdiv_nphase_if.sv
// clkdiv_nphase_if: control and output bundle of the multi-phase clock/PWM generator
interface clkdiv_nphase_if #(
    parameter int WIDTH = 15,
    parameter int CH    = 2
);
    logic                  en;
    logic                  load;
    logic [WIDTH-1:0]      div_in;
    logic [WIDTH-1:0]      duty_in;
    logic [CH*WIDTH-1:0]   phase_in;
    logic [CH-1:0]         clkout;
    logic                  tick;
    logic                  pending;
    logic                  cfg_err;
    modport master (output en, load, div_in, duty_in, phase_in, input clkout, tick, pending, cfg_err);
    modport slave  (input en, load, div_in, duty_in, phase_in, output clkout, tick, pending, cfg_err);
endinterface

// File: rtl/clkdiv_nphase.sv
// clkdiv_nphase: shared period counter driving CH phase-shifted PWM outputs with shadowed configuration
module clkdiv_nphase #(
    parameter int WIDTH   = 15,
    parameter int CH      = 2,
    parameter int DEF_DIV = 100
) (
    input logic            clk,
    input logic            rst,
    clkdiv_nphase_if.slave bus
);
    localparam logic [WIDTH-1:0] DEF_D    = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] DEF_DUTY = WIDTH'(DEF_DIV >> 1);
    logic [WIDTH-1:0]    cnt, div_a, duty_a, div_s, duty_s;
    logic [CH*WIDTH-1:0] ph_a, ph_s;
    logic [CH-1:0]       clkout_r, hi, bad;
    logic                tick_r, pending_r, idle, last, apply;
    assign idle  = !bus.en || div_a == '0;
    assign last  = cnt == div_a - 1'b1;
    assign apply = idle || last;
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [WIDTH-1:0] ph, eff;
        logic [WIDTH:0]   c, e, pos;
        assign ph     = ph_a[i*WIDTH +: WIDTH];
        assign bad[i] = ph >= div_a;
        assign eff    = bad[i] ? '0 : ph;
        assign c      = {1'b0, cnt};
        assign e      = {1'b0, eff};
        assign pos    = (c >= e) ? c - e : c + {1'b0, div_a} - e;
        assign hi[i]  = pos < {1'b0, duty_a};
    end
    assign bus.clkout  = clkout_r;
    assign bus.tick    = tick_r;
    assign bus.pending = pending_r;
    assign bus.cfg_err = |bad;
    // counter, registered outputs and shadow-to-active transfer at period boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            div_a     <= DEF_D;
            duty_a    <= DEF_DUTY;
            ph_a      <= '0;
            div_s     <= '0;
            duty_s    <= '0;
            ph_s      <= '0;
            pending_r <= 1'b0;
            clkout_r  <= '0;
            tick_r    <= 1'b0;
        end else begin
            clkout_r <= idle ? '0 : hi;
            tick_r   <= !idle && cnt == '0;
            cnt      <= apply ? '0 : cnt + 1'b1;
            if (apply && bus.load) begin
                div_a     <= bus.div_in;
                duty_a    <= bus.duty_in;
                ph_a      <= bus.phase_in;
                pending_r <= 1'b0;
            end else if (apply && pending_r) begin
                div_a     <= div_s;
                duty_a    <= duty_s;
                ph_a      <= ph_s;
                pending_r <= 1'b0;
            end else if (bus.load) begin
                div_s     <= bus.div_in;
                duty_s    <= bus.duty_in;
                ph_s      <= bus.phase_in;
                pending_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clkdiv_nphase.sv
// tb_clkdiv_nphase: table, directed and randomized checks against a cycle-level arithmetic model
module tb_clkdiv_nphase;
    localparam int WIDTH = 15, CH = 2, DEF_DIV = 100;
    typedef struct {int div; int duty; int ph0; int ph1; int err; int hi0; int hi1;} vec_t;
    logic clk = 1'b0, rst;
    int checks = 0, failures = 0;
    int m_cnt, m_div, m_duty, s_div, s_duty, m_pend;
    int m_ph[CH], s_ph[CH];
    logic [CH-1:0] e_clk;
    logic e_tick;
    vec_t tbl[6];
    int n, hi0, hi1, ticks;
    logic [4:0] p0, p1;
    clkdiv_nphase_if #(.WIDTH(WIDTH), .CH(CH)) bus ();
    clkdiv_nphase #(.WIDTH(WIDTH), .CH(CH), .DEF_DIV(DEF_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask
    // next expected state from the current inputs, using plain modular arithmetic
    function automatic void model_step();
        int eff, bnd, idle;
        if (rst) begin
            m_cnt = 0; m_div = DEF_DIV; m_duty = DEF_DIV >> 1; m_pend = 0;
            foreach (m_ph[k]) m_ph[k] = 0;
            e_clk = '0; e_tick = 1'b0;
            return;
        end
        idle = (!bus.en || m_div == 0) ? 1 : 0;
        e_tick = !idle && m_cnt == 0;
        for (int k = 0; k < CH; k++) begin
            eff = (m_ph[k] >= m_div) ? 0 : m_ph[k];
            e_clk[k] = !idle && ((m_cnt - eff + m_div) % m_div) < m_duty;
        end
        bnd = (idle || m_cnt == m_div - 1) ? 1 : 0;
        m_cnt = idle ? 0 : (m_cnt + 1) % m_div;
        if (bnd && bus.load) begin
            m_div = bus.div_in; m_duty = bus.duty_in; m_pend = 0;
            for (int k = 0; k < CH; k++) m_ph[k] = bus.phase_in[k*WIDTH +: WIDTH];
        end else if (bnd && m_pend) begin
            m_div = s_div; m_duty = s_duty; m_ph = s_ph; m_pend = 0;
        end else if (bus.load) begin
            s_div = bus.div_in; s_duty = bus.duty_in; m_pend = 1;
            for (int k = 0; k < CH; k++) s_ph[k] = bus.phase_in[k*WIDTH +: WIDTH];
        end
    endfunction
    task automatic cyc();
        int err;
        model_step();
        @(posedge clk);
        @(negedge clk);
        err = 0;
        foreach (m_ph[k]) if (m_ph[k] >= m_div) err = 1;
        chk("cycle", int'({bus.clkout, bus.tick, bus.pending, bus.cfg_err}), int'({e_clk, e_tick, m_pend[0], err[0]}));
    endtask
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!bus.tick && cnt < 400);
        if (!bus.tick) chk("tick_timeout", 0, 1);
    endtask
    task automatic idle_load(input int div, input int duty, input int ph0, input int ph1);
        bus.en = 1'b0;
        bus.div_in = WIDTH'(div);
        bus.duty_in = WIDTH'(duty);
        bus.phase_in = {WIDTH'(ph1), WIDTH'(ph0)};
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        bus.en = 1'b1;
    endtask
    task automatic run_load(input int div, input int duty);
        bus.div_in = WIDTH'(div);
        bus.duty_in = WIDTH'(duty);
        bus.phase_in = '0;
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask
    initial begin
        tbl[0] = '{5, 2, 2, 0, 0, 2, 2};
        tbl[1] = '{8, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{8, 9, 0, 0, 0, 8, 8};
        tbl[3] = '{1, 1, 0, 0, 0, 1, 1};
        tbl[4] = '{4, 2, 6, 0, 1, 2, 2};
        tbl[5] = '{7, 3, 1, 6, 0, 3, 3};
        rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0;
        bus.div_in = '0; bus.duty_in = '0; bus.phase_in = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_outputs", int'({bus.clkout, bus.tick}), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        bus.en = 1'b1;
        wait_tick(n);
        chk("def_first_tick", n, 1);
        hi0 = 0; hi1 = 0; ticks = 0;
        for (int i = 0; i < DEF_DIV; i++) begin
            hi0 += int'(bus.clkout[0]); hi1 += int'(bus.clkout[1]); ticks += int'(bus.tick);
            cyc();
        end
        chk("def_high0", hi0, 50);
        chk("def_high1", hi1, 50);
        chk("def_ticks", ticks, 1);
        idle_load(5, 2, 0, 2);
        wait_tick(n);
        p0 = '0; p1 = '0;
        for (int i = 0; i < 5; i++) begin
            p0 = {p0[3:0], bus.clkout[0]};
            p1 = {p1[3:0], bus.clkout[1]};
            cyc();
        end
        chk("twophase_ch0", int'(p0), int'(5'b11000));
        chk("twophase_ch1", int'(p1), int'(5'b00110));
        wait_tick(n);
        cyc();
        run_load(8, 4);
        chk("mid_pending", int'(bus.pending), 1);
        wait_tick(n);
        chk("mid_old_period_end", n, 3);
        wait_tick(n);
        chk("mid_new_period", n, 8);
        repeat (6) cyc();
        run_load(3, 1);
        chk("simul_pending", int'(bus.pending), 0);
        wait_tick(n);
        chk("simul_first_tick", n, 1);
        wait_tick(n);
        chk("simul_new_period", n, 3);
        foreach (tbl[t]) begin
            idle_load(tbl[t].div, tbl[t].duty, tbl[t].ph0, tbl[t].ph1);
            wait_tick(n);
            hi0 = 0; hi1 = 0; ticks = 0;
            for (int i = 0; i < tbl[t].div; i++) begin
                hi0 += int'(bus.clkout[0]); hi1 += int'(bus.clkout[1]); ticks += int'(bus.tick);
                cyc();
            end
            chk($sformatf("tbl%0d_high0", t), hi0, tbl[t].hi0);
            chk($sformatf("tbl%0d_high1", t), hi1, tbl[t].hi1);
            chk($sformatf("tbl%0d_ticks", t), ticks, 1);
            chk($sformatf("tbl%0d_cfg_err", t), int'(bus.cfg_err), tbl[t].err);
        end
        idle_load(0, 3, 0, 0);
        repeat (5) cyc();
        chk("div0_outputs", int'({bus.clkout, bus.tick}), 0);
        idle_load(6, 3, 0, 3);
        wait_tick(n);
        cyc();
        bus.en = 1'b0;
        cyc();
        chk("en_low_outputs", int'({bus.clkout, bus.tick}), 0);
        bus.en = 1'b1;
        cyc();
        chk("en_restart_tick", int'(bus.tick), 1);
        cyc();
        run_load(9, 2);
        chk("prerst_pending", int'(bus.pending), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_pending_clear", int'(bus.pending), 0);
        wait_tick(n);
        wait_tick(n);
        chk("rst_default_period", n, DEF_DIV);
        for (int c = 0; c < 600; c++) begin
            rst = $urandom_range(0, 199) == 0;
            bus.en = $urandom_range(0, 15) != 0;
            bus.load = $urandom_range(0, 7) == 0;
            bus.div_in = WIDTH'($urandom_range(0, 12));
            bus.duty_in = WIDTH'($urandom_range(0, 14));
            for (int k = 0; k < CH; k++)
                bus.phase_in[k*WIDTH +: WIDTH] = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 13));
            cyc();
        end
        rst = 1'b0; bus.load = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
